// File: rtl/inst_queue_reg.sv
// Instruction queue + instruction register: buffers fetched {inst, pc} words in a
// DEPTH-entry circular FIFO and loads the head into a decoded IR on IRWrite.
// Latency: push at edge N is poppable at edge N+1; IR fields are registered.
// Backpressure: in_ready = !full from registered count only; flush dominates push/pop.
//
// Ports:
//   clk, reset (async, active-high)
//   flush                          - empty the queue and turn the IR into a NOP
//   in_valid/in_ready/in_inst/in_pc - fetch-side push interface
//   IRWrite                        - pop the head into the IR
//   ExtOp                          - 1 = sign-extend Imm16 onto ImmExt, 0 = zero-extend
//   ir_valid, stall                - IR holds a live instruction / IRWrite on empty queue
//   OpCode, rs, rt, rd, Shamt, Funct, Imm16, JumpIdx, ImmExt, ir_pc - decoded IR
//   count                          - entries waiting in the queue (IR not included)
module inst_queue_reg #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_inst,
    input  logic [PC_WIDTH-1:0]          in_pc,
    input  logic                         IRWrite,
    input  logic                         ExtOp,
    output logic                         ir_valid,
    output logic                         stall,
    output logic [5:0]                   OpCode,
    output logic [4:0]                   rs,
    output logic [4:0]                   rt,
    output logic [4:0]                   rd,
    output logic [4:0]                   Shamt,
    output logic [5:0]                   Funct,
    output logic [15:0]                  Imm16,
    output logic [31:0]                  ImmExt,
    output logic [25:0]                  JumpIdx,
    output logic [PC_WIDTH-1:0]          ir_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]         inst_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem   [DEPTH];

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       cnt;

    logic [31:0]         ir;
    logic [PC_WIDTH-1:0] ir_pc_q;
    logic                ir_valid_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // A same-cycle pop never frees a slot for the push: in_ready only sees
    // registered count, which keeps the ready path free of IRWrite.
    assign push = in_valid && !full && !flush;
    assign pop  = IRWrite && !empty && !flush;

    // Storage carries no reset; stale contents are never read because
    // count gates every pop.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // IRWrite on an empty queue keeps the old fields (for debug visibility)
    // but marks them dead so the controller does not re-execute them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir         <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else if (flush) begin
            ir         <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else if (pop) begin
            ir         <= inst_mem[rd_ptr];
            ir_pc_q    <= pc_mem[rd_ptr];
            ir_valid_q <= 1'b1;
        end else if (IRWrite) begin
            ir_valid_q <= 1'b0;
        end
    end

    assign in_ready = !full;
    assign stall    = IRWrite && empty;
    assign count    = cnt;
    assign ir_valid = ir_valid_q;
    assign ir_pc    = ir_pc_q;

    assign OpCode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign Shamt    = ir[10:6];
    assign Funct    = ir[5:0];
    assign Imm16    = ir[15:0];
    assign JumpIdx  = ir[25:0];

    // Follows ExtOp live so the controller can switch extension mode
    // mid-instruction without reloading the IR.
    assign ImmExt   = ExtOp ? {{16{ir[15]}}, ir[15:0]} : {16'h0000, ir[15:0]};

endmodule

// File: tb/tb_inst_queue_reg.sv
module tb_inst_queue_reg;

    localparam int DEPTH = 4;
    localparam int PW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_inst;
    logic [PW-1:0] in_pc;
    logic          IRWrite;
    logic          ExtOp;
    logic          ir_valid;
    logic          stall;
    logic [5:0]    OpCode;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    Shamt;
    logic [5:0]    Funct;
    logic [15:0]   Imm16;
    logic [31:0]   ImmExt;
    logic [25:0]   JumpIdx;
    logic [PW-1:0] ir_pc;
    logic [CW-1:0] count;

    inst_queue_reg #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .IRWrite(IRWrite), .ExtOp(ExtOp), .ir_valid(ir_valid), .stall(stall),
        .OpCode(OpCode), .rs(rs), .rt(rt), .rd(rd), .Shamt(Shamt), .Funct(Funct),
        .Imm16(Imm16), .ImmExt(ImmExt), .JumpIdx(JumpIdx), .ir_pc(ir_pc), .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain queue of {pc, inst} plus the IR contents.
    logic [63:0]   mq [$];
    logic [31:0]   m_ir;
    logic [PW-1:0] m_pc;
    logic          m_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_comb();
        logic [15:0] imm;
        logic [31:0] ext;
        imm = m_ir[15:0];
        ext = ExtOp ? 32'($signed(imm)) : 32'(imm);
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("stall", 64'(stall), 64'(IRWrite && mq.size() == 0));
        chk("ImmExt", 64'(ImmExt), 64'(ext));
    endtask

    task automatic check_regs();
        chk("count", 64'(count), 64'(mq.size()));
        chk("ir_valid", 64'(ir_valid), 64'(m_v));
        chk("OpCode", 64'(OpCode), 64'(m_ir[31:26]));
        chk("rs", 64'(rs), 64'(m_ir[25:21]));
        chk("rt", 64'(rt), 64'(m_ir[20:16]));
        chk("rd", 64'(rd), 64'(m_ir[15:11]));
        chk("Shamt", 64'(Shamt), 64'(m_ir[10:6]));
        chk("Funct", 64'(Funct), 64'(m_ir[5:0]));
        chk("Imm16", 64'(Imm16), 64'(m_ir[15:0]));
        chk("JumpIdx", 64'(JumpIdx), 64'(m_ir[25:0]));
        chk("ir_pc", 64'(ir_pc), 64'(m_pc));
    endtask

    task automatic step(input logic f, input logic v, input logic [31:0] inst,
                        input logic [PW-1:0] pc, input logic irw, input logic ext);
        int pre;
        logic [63:0] e;
        @(negedge clk);
        flush = f; in_valid = v; in_inst = inst; in_pc = pc; IRWrite = irw; ExtOp = ext;
        #1 check_comb();
        @(posedge clk);
        pre = mq.size();
        if (f) begin
            mq.delete();
            m_ir = '0; m_pc = '0; m_v = 1'b0;
        end else begin
            if (irw && pre != 0) begin
                e = mq.pop_front();
                m_ir = e[31:0]; m_pc = e[63:32]; m_v = 1'b1;
            end else if (irw) begin
                m_v = 1'b0;
            end
            if (v && pre < DEPTH) mq.push_back({pc, inst});
        end
        #1 check_regs();
    endtask

    // Reset is raised between edges so its effect is checked as asynchronous.
    task automatic do_reset();
        @(negedge clk);
        #2;
        flush = 1'b0; in_valid = 1'b0; IRWrite = 1'b1;
        reset = 1'b1;
        mq.delete();
        m_ir = '0; m_pc = '0; m_v = 1'b0;
        #1;
        check_regs();
        check_comb();
        @(negedge clk);
        reset = 1'b0; IRWrite = 1'b0;
    endtask

    localparam logic [31:0] A = 32'h8C880004;
    localparam logic [31:0] B = 32'h00851020;
    localparam logic [31:0] C = 32'h3C01ABCD;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        IRWrite = 1'b0; ExtOp = 1'b0;
        m_ir = '0; m_pc = '0; m_v = 1'b0;

        do_reset();

        // Basic fetch-to-IR path and field decode.
        step(0, 1, A, 32'h0, 0, 0);
        step(0, 1, B, 32'h4, 0, 0);
        step(0, 0, 32'h0, 32'h0, 1, 0);
        chk("A_opcode", 64'(OpCode), 64'h23);
        chk("A_rs", 64'(rs), 64'd4);
        chk("A_rt", 64'(rt), 64'd8);
        chk("A_imm", 64'(Imm16), 64'd4);
        chk("A_pc", 64'(ir_pc), 64'h0);
        step(0, 0, 32'h0, 32'h0, 1, 0);
        chk("B_funct", 64'(Funct), 64'h20);
        chk("B_rd", 64'(rd), 64'd2);
        chk("B_pc", 64'(ir_pc), 64'h4);
        chk("AB_count", 64'(count), 64'd0);

        // Fill to full, overflow push refused, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 32'h1000_0000 + 32'(i), 32'(8 * i), 0, 0);
            if (i == 4) chk("full_ready", 64'(in_ready), 64'd0);
        end
        chk("full_count", 64'(count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 32'h0, 32'h0, 1, 0);
            chk("drain_inst", 64'({OpCode, rs, rt, rd, Shamt, Funct}), 64'(32'h1000_0000 + 32'(i)));
            chk("drain_pc", 64'(ir_pc), 64'(8 * i));
        end

        // Immediate extension follows ExtOp without reloading the IR.
        step(0, 1, 32'h2000FFF0, 32'h40, 0, 0);
        step(0, 0, 32'h0, 32'h0, 1, 0);
        ExtOp = 1'b1;
        #1 chk("imm_sext", 64'(ImmExt), 64'hFFFF_FFF0);
        ExtOp = 1'b0;
        #1 chk("imm_zext", 64'(ImmExt), 64'h0000_FFF0);
        chk("imm_hold", 64'(Imm16), 64'hFFF0);

        // IRWrite on empty queue with a simultaneous push: no bypass.
        step(0, 1, C, 32'h50, 1, 0);
        chk("bypass_valid", 64'(ir_valid), 64'd0);
        chk("bypass_imm", 64'(Imm16), 64'hFFF0);
        chk("bypass_count", 64'(count), 64'd1);
        step(0, 0, 32'h0, 32'h0, 1, 0);
        chk("C_valid", 64'(ir_valid), 64'd1);
        chk("C_opcode", 64'(OpCode), 64'h0F);

        // Flush beats a same-cycle push and pop.
        for (int i = 0; i < 3; i++) step(0, 1, 32'hA000_0000 + 32'(i), 32'(i), 0, 0);
        step(1, 1, 32'hDEAD_BEEF, 32'h99, 1, 0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(ir_valid), 64'd0);
        chk("flush_ir", 64'({OpCode, rs, rt, rd, Shamt, Funct}), 64'd0);
        chk("flush_pc", 64'(ir_pc), 64'd0);

        // Streaming across a pointer wrap, then reset mid-stream.
        step(0, 1, 32'hB000_0000, 32'h100, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 32'hB000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1, 0);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", 64'(ir_pc), 64'(32'h100 + 32'(4 * (i - 1))));
        end
        do_reset();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step(($urandom_range(0, 24) == 0), 1'($urandom), $urandom, $urandom,
                 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
